t05_cb_header_writer: RTL and testbench



---
 rtl/t05_pkg.sv | 19 +
 rtl/t05_bit_packer.sv | 58 +++++
 rtl/t05_cb_header_writer.sv | 177 +++++++++++++++++
 tb/tb_t05_cb_header_writer.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/t05_pkg.sv
// Shared types and header-field widths for the codebook header writer.
package t05_pkg;

  typedef enum logic [2:0] {IDLE, LOAD, HDR, PATH, DONE, FLUSH, CNT, FIN} cbw_state_t;

  localparam logic [3:0] CB_CODEBOOK_STATE = 4'd4;
  localparam int         HDR_CHAR_W        = 8;
  localparam int         HDR_LEN_W         = 7;
  localparam int         HDR_W             = HDR_CHAR_W + HDR_LEN_W;

  // Path length is the index of the control bit; 0 and 1 both encode an empty path.
  function automatic logic [HDR_LEN_W-1:0] path_len(input logic [127:0] path);
    path_len = '0;
    for (int i = 1; i < 128; i++) begin
      if (path[i]) path_len = i[HDR_LEN_W-1:0];
    end
  endfunction

endpackage

// File: rtl/t05_bit_packer.sv
// Bit-to-byte packer, first bit lands in bit 7; a byte is offered once 8 bits are held.
// Stalls input only while a full byte waits on out_ready; pad zero-fills a partial byte.
module t05_bit_packer (
  input  logic       clk,
  input  logic       rst,
  input  logic       bit_valid,
  input  logic       bit_data,
  output logic       bit_ready,
  input  logic       pad,
  output logic       empty,
  output logic [7:0] out_byte,
  output logic       out_valid,
  input  logic       out_ready
);

  logic [7:0] sreg, sreg_n;
  logic [3:0] cnt, cnt_n;
  logic       push, xfer;

  assign xfer      = out_valid && out_ready;
  assign bit_ready = (cnt != 4'd8) || out_ready;
  assign push      = bit_valid && bit_ready;
  assign empty     = (cnt == 4'd0);
  assign out_byte  = sreg;

  always_comb begin
    sreg_n = sreg;
    cnt_n  = cnt;
    if (push) begin
      if (xfer) begin
        sreg_n = {7'b0, bit_data};
        cnt_n  = 4'd1;
      end else begin
        sreg_n = {sreg[6:0], bit_data};
        cnt_n  = cnt + 4'd1;
      end
    end else if (xfer) begin
      sreg_n = '0;
      cnt_n  = 4'd0;
    end else if (pad && cnt != 4'd0 && cnt != 4'd8) begin
      sreg_n = sreg << (4'd8 - cnt);
      cnt_n  = 4'd8;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sreg      <= '0;
      cnt       <= '0;
      out_valid <= 1'b0;
    end else begin
      sreg      <= sreg_n;
      cnt       <= cnt_n;
      out_valid <= (cnt_n == 4'd8);
    end
  end

endmodule

// File: rtl/t05_cb_header_writer.sv
// Serializes {char, len, path} codebook records into a byte stream; first header bit packs 2 cycles after capture.
// Stalls on out_ready via the packer; T05_CBW_COUNT_EN appends a record-count byte after the flush pad.
module t05_cb_header_writer
  import t05_pkg::*;
#(
  parameter int BYTE_W = 8,
  parameter int PATH_W = 128
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [3:0]        en_state,
  input  logic              char_found,
  input  logic [7:0]        char_index,
  input  logic [PATH_W-1:0] char_path,
  input  logic              flush,
  input  logic              out_ready,
  output logic [BYTE_W-1:0] out_byte,
  output logic              out_valid,
  output logic              write_finish,
  output logic              flush_done,
  output logic              busy
);

  cbw_state_t           state, state_n;
  logic [7:0]           idx_q;
  logic [PATH_W-1:0]    path_q;
  logic [HDR_LEN_W-1:0] len_q, len_calc, pidx;
  logic [HDR_W-1:0]     hdr_sr;
  logic [3:0]           hdr_left;
  logic                 bit_valid, bit_data, bit_ready, pad, empty;
  logic                 cap, load, hdr_step, path_step;
`ifdef T05_CBW_COUNT_EN
  logic [7:0]           rec_cnt;
  logic                 cnt_load;
`endif

  assign len_calc = path_len(path_q);

  t05_bit_packer u_packer (
    .clk       (clk),
    .rst       (rst),
    .bit_valid (bit_valid),
    .bit_data  (bit_data),
    .bit_ready (bit_ready),
    .pad       (pad),
    .empty     (empty),
    .out_byte  (out_byte),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  always_comb begin
    state_n   = state;
    bit_valid = 1'b0;
    bit_data  = 1'b0;
    pad       = 1'b0;
    cap       = 1'b0;
    load      = 1'b0;
    hdr_step  = 1'b0;
    path_step = 1'b0;
`ifdef T05_CBW_COUNT_EN
    cnt_load  = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (char_found && en_state == CB_CODEBOOK_STATE) begin
          cap     = 1'b1;
          state_n = LOAD;
        end else if (flush) begin
          state_n = FLUSH;
        end
      end
      LOAD: begin
        load    = 1'b1;
        state_n = HDR;
      end
      HDR: begin
        bit_valid = 1'b1;
        bit_data  = hdr_sr[HDR_W-1];
        if (bit_ready) begin
          hdr_step = 1'b1;
          if (hdr_left == 4'd1) state_n = (len_q == '0) ? DONE : PATH;
        end
      end
      PATH: begin
        bit_valid = 1'b1;
        bit_data  = path_q[pidx];
        if (bit_ready) begin
          path_step = 1'b1;
          if (pidx == '0) state_n = DONE;
        end
      end
      DONE: begin
        if (en_state == CB_CODEBOOK_STATE) state_n = IDLE;
      end
      FLUSH: begin
        pad = 1'b1;
        if (empty) begin
`ifdef T05_CBW_COUNT_EN
          cnt_load = 1'b1;
          state_n  = CNT;
`else
          state_n  = FIN;
`endif
        end
      end
`ifdef T05_CBW_COUNT_EN
      CNT: begin
        // Count byte reuses the header shift register and its bit counter.
        if (hdr_left != 4'd0) begin
          bit_valid = 1'b1;
          bit_data  = hdr_sr[HDR_W-1];
          if (bit_ready) hdr_step = 1'b1;
        end else if (empty) begin
          state_n = FIN;
        end
      end
`endif
      FIN:     state_n = FIN;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      write_finish <= 1'b0;
      flush_done   <= 1'b0;
      busy         <= 1'b0;
    end else begin
      state        <= state_n;
      write_finish <= (state_n == DONE);
      flush_done   <= (state_n == FIN);
      busy         <= (state_n != IDLE) && (state_n != FIN);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q    <= '0;
      path_q   <= '0;
      len_q    <= '0;
      hdr_sr   <= '0;
      hdr_left <= '0;
      pidx     <= '0;
`ifdef T05_CBW_COUNT_EN
      rec_cnt  <= '0;
`endif
    end else begin
      if (cap) begin
        idx_q  <= char_index;
        path_q <= char_path;
`ifdef T05_CBW_COUNT_EN
        rec_cnt <= rec_cnt + 8'd1;
`endif
      end
      if (load) begin
        len_q    <= len_calc;
        hdr_sr   <= {idx_q, len_calc};
        hdr_left <= 4'd15;
        pidx     <= len_calc - 7'd1;
      end
      if (hdr_step) begin
        hdr_sr   <= {hdr_sr[HDR_W-2:0], 1'b0};
        hdr_left <= hdr_left - 4'd1;
      end
      if (path_step) pidx <= pidx - 7'd1;
`ifdef T05_CBW_COUNT_EN
      if (cnt_load) begin
        hdr_sr   <= {rec_cnt, 7'b0};
        hdr_left <= 4'd8;
      end
`endif
    end
  end

endmodule

// File: tb/tb_t05_cb_header_writer.sv
// Scoreboard bench for the codebook header writer: expected bytes are queued at record/flush time.
module tb_t05_cb_header_writer;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [3:0]   en_state = 4'd0;
  logic         char_found = 1'b0;
  logic [7:0]   char_index = 8'd0;
  logic [127:0] char_path = '0;
  logic         flush = 1'b0;
  logic         out_ready = 1'b1;
  logic [7:0]   out_byte;
  logic         out_valid, write_finish, flush_done, busy;

  int         n_chk = 0;
  int         n_fail = 0;
  int         ready_mode = 0;
  logic [7:0] exp_q[$];
  logic [7:0] acc = 8'd0;
  int         nacc = 0;
  int         rec_n = 0;

  t05_cb_header_writer dut (
    .clk          (clk),
    .rst          (rst),
    .en_state     (en_state),
    .char_found   (char_found),
    .char_index   (char_index),
    .char_path    (char_path),
    .flush        (flush),
    .out_ready    (out_ready),
    .out_byte     (out_byte),
    .out_valid    (out_valid),
    .write_finish (write_finish),
    .flush_done   (flush_done),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = 1'b0;
      default: out_ready = 1'($urandom_range(0, 1));
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic put_bit(input logic b);
    acc = {acc[6:0], b};
    nacc++;
    if (nacc == 8) begin
      exp_q.push_back(acc);
      acc  = 8'd0;
      nacc = 0;
    end
  endtask

  function automatic int mlen(input logic [127:0] p);
    int l = 0;
    for (int i = 1; i < 128; i++) if (p[i]) l = i;
    return l;
  endfunction

  task automatic clear_model();
    exp_q.delete();
    acc   = 8'd0;
    nacc  = 0;
    rec_n = 0;
  endtask

  task automatic model_flush();
    if (nacc > 0) begin
      exp_q.push_back(acc << (8 - nacc));
      acc  = 8'd0;
      nacc = 0;
    end
`ifdef T05_CBW_COUNT_EN
    exp_q.push_back(rec_n[7:0]);
`endif
  endtask

  // Called just after a rising edge with the DUT idle; returns just after the capture edge.
  task automatic rec_start(input logic [7:0] ch, input logic [127:0] p);
    int l = mlen(p);
    char_index = ch;
    char_path  = p;
    char_found = 1'b1;
    en_state   = 4'd4;
    for (int i = 7; i >= 0; i--) put_bit(ch[i]);
    for (int i = 6; i >= 0; i--) put_bit(l[i]);
    for (int i = l - 1; i >= 0; i--) put_bit(p[i]);
    rec_n++;
    @(posedge clk);
    #1;
    char_found = 1'b0;
  endtask

  task automatic wait_wf(input int budget, output int n);
    n = 0;
    while (n < budget && !write_finish) begin
      @(posedge clk);
      n++;
      @(negedge clk);
    end
    chk("write_finish_seen", write_finish, 1);
  endtask

  task automatic wait_fd(input int budget);
    int n = 0;
    while (n < budget && !flush_done) begin
      @(posedge clk);
      n++;
      @(negedge clk);
    end
    chk("flush_done", flush_done, 1);
    chk("fin_busy", busy, 0);
    chk("drained", exp_q.size(), 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_out_byte"}, out_byte, 0);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_write_finish"}, write_finish, 0);
    chk({tag, "_flush_done"}, flush_done, 0);
    chk({tag, "_busy"}, busy, 0);
  endtask

  task automatic do_reset();
    rst   = 1'b1;
    flush = 1'b0;
    clear_model();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Every transfer pops the next expected byte; a stalled byte must match the queue head.
  always @(negedge clk) begin
    logic [8:0] e;
    if (!rst && out_valid) begin
      e = 9'h100;
      if (out_ready) begin
        if (exp_q.size() != 0) e = {1'b0, exp_q.pop_front()};
        chk("byte", {1'b0, out_byte}, e);
      end else begin
        if (exp_q.size() != 0) e = {1'b0, exp_q[0]};
        chk("byte_hold", {1'b0, out_byte}, e);
      end
    end
  end

  initial begin
    int           n;
    int           l;
    logic [127:0] p, m;

    do_reset();

    // Basic record: 0x41, L=3 -> bytes 0x41, 0x06, two bits pending.
    rec_start(8'h41, 128'b1010);
    wait_wf(100, n);
    chk("wf_latency_basic", n, 19);
    chk("busy_in_done", busy, 1);
    @(posedge clk);
    @(negedge clk);
    chk("wf_clear_basic", write_finish, 0);
    chk("partial_not_valid", out_valid, 0);
    chk("idle_not_busy", busy, 0);
    @(posedge clk);
    #1;
    flush = 1'b1;
    model_flush();
    wait_fd(100);
    flush = 1'b0;

    // Zero-length record: header only.
    do_reset();
    rec_start(8'hFF, 128'd1);
    wait_wf(100, n);
    chk("wf_latency_zero", n, 16);
    @(posedge clk);
    #1;

    // Back-pressure mid-record plus a delayed write_finish handshake.
    rec_start(8'h5A, 128'h1ABCDE);
    en_state = 4'd0;
    repeat (12) @(posedge clk);
    #1;
    ready_mode = 1;
    repeat (20) @(posedge clk);
    #1;
    ready_mode = 0;
    wait_wf(200, n);
    repeat (5) begin
      @(negedge clk);
      chk("wf_hold", write_finish, 1);
    end
    @(posedge clk);
    #1;
    en_state = 4'd4;
    @(negedge clk);
    chk("wf_sampled", write_finish, 1);
    @(posedge clk);
    @(negedge clk);
    chk("wf_clear_hs", write_finish, 0);
    @(posedge clk);
    #1;

    // Random records under random back-pressure, then flush.
    ready_mode = 2;
    for (int k = 0; k < 6; k++) begin
      l = $urandom_range(0, 127);
      m = (128'd1 << l) - 128'd1;
      p = ({$urandom(), $urandom(), $urandom(), $urandom()} & m) | (128'd1 << l);
      rec_start(8'($urandom()), p);
      wait_wf(2000, n);
      @(posedge clk);
      #1;
    end
    flush = 1'b1;
    model_flush();
    wait_fd(500);
    flush = 1'b0;
    ready_mode = 0;

    // Reset during header bit 7, then a fresh record must start byte-aligned.
    do_reset();
    rec_start(8'hC3, 128'h1_0000_0400);
    repeat (7) @(posedge clk);
    #1;
    rst = 1'b1;
    clear_model();
    @(posedge clk);
    @(negedge clk);
    check_reset_outputs("midrec");
    @(posedge clk);
    #1;
    rst = 1'b0;
    rec_start(8'h3C, 128'b100101);
    wait_wf(100, n);
    chk("wf_latency_after_rst", n, 21);
    @(posedge clk);
    #1;
    flush = 1'b1;
    model_flush();
    wait_fd(100);
    flush = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
